// File: rtl/sw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sw_input_conditioner
// Purpose  : Conditions the board slide switches before they reach the CPU
//            `sw` input. Each bit passes through a 2-flop synchroniser and a
//            counter-based debouncer, producing a registered stable level
//            plus one-cycle rise/fall event pulses.
// Ports    : clk         - system clock, rising edge
//            rst         - synchronous active-high reset
//            sw_raw      - asynchronous switch pins
//            sw_out      - debounced stable level (feeds cpu `sw`)
//            rise_pulse  - one-cycle pulse per bit on stable 0->1
//            fall_pulse  - one-cycle pulse per bit on stable 1->0
//            evt_clr     - per-bit clear of sticky event flags
//            evt_pending - sticky per-bit event flags
// Options  : SW_EVENT_LATCH_EN - when defined, evt_pending latches any
//            rise/fall pulse until cleared by evt_clr. When undefined,
//            evt_pending is tied to 0 and evt_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sw_input_conditioner #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   input  logic [WIDTH-1:0] evt_clr,
   output logic [WIDTH-1:0] evt_pending
);

   // Terminal count: a mismatch seen while the counter already holds this
   // value is the DEBOUNCE_CYCLES-th consecutive one, so the level flips.
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] sw_out_q;
   logic [WIDTH-1:0] sw_out_d;
   logic [WIDTH-1:0] rise_pulse_q;
   logic [WIDTH-1:0] rise_pulse_d;
   logic [WIDTH-1:0] fall_pulse_q;
   logic [WIDTH-1:0] fall_pulse_d;

   // Per-bit debounce. Any match clears the count, so a glitch shorter than
   // the debounce window leaves no trace; the counter also clears on a flip,
   // which keeps it bounded by c_cnt_max.
   always_comb begin
      sw_out_d     = sw_out_q;
      rise_pulse_d = '0;
      fall_pulse_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != sw_out_q[i]) begin
            if (cnt_q[i] == c_cnt_max) begin
               sw_out_d[i]     = sync2_q[i];
               rise_pulse_d[i] = sync2_q[i];
               fall_pulse_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         sw_out_q     <= '0;
         rise_pulse_q <= '0;
         fall_pulse_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= sw_raw;
         sync2_q      <= sync1_q;
         sw_out_q     <= sw_out_d;
         rise_pulse_q <= rise_pulse_d;
         fall_pulse_q <= fall_pulse_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_out     = sw_out_q;
   assign rise_pulse = rise_pulse_q;
   assign fall_pulse = fall_pulse_q;

`ifdef SW_EVENT_LATCH_EN
   logic [WIDTH-1:0] evt_pending_q;
   logic [WIDTH-1:0] evt_pending_d;

   // Set terms come from the pulse next-state so the flag rises on the same
   // edge as the pulse; set is OR-ed last so it wins over a same-cycle clear.
   always_comb begin
      evt_pending_d = (evt_pending_q & ~evt_clr) | rise_pulse_d | fall_pulse_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_pending_q <= '0;
      end else begin
         evt_pending_q <= evt_pending_d;
      end
   end

   assign evt_pending = evt_pending_q;
`else
   // Feature disabled: no sticky state; evt_clr is intentionally unused.
   logic unused_evt_clr;
   assign unused_evt_clr = ^evt_clr;
   assign evt_pending    = '0;
`endif

endmodule
`default_nettype wire
